control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Generates the FETCH/EXEC1/EXEC2 phase strobes and the latched opcode consumed by the CPU instruction decoder. It closes the loop by sampling the decoder's EXTRA request to choose the instruction length.
- Sits between program memory read data and the decoder. It owns the instruction register, run/single-step control, halt on STP, and the cycle and instruction counters.

Parameters:
- DATA_W, 16, width of the memory read word.
- OPC_W, 4, opcode width; the opcode is taken from the MSBs MEM_Q[DATA_W-1 -: OPC_W].
- CNT_W, 16, width of CYCLE_CNT and INSTR_CNT.
- STP_OPC, 4'b0111, opcode that halts the sequencer.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- RUN  input  1  level; 1 = free-run instructions.
- STEP  input  1  single-cycle pulse; executes one instruction when idle and RUN=0.
- EXTRA  input  1  from the decoder; 1 = the instruction needs EXEC2. Sampled only in EXEC1.
- MEM_Q  input  DATA_W  instruction word; valid during the FETCH cycle.
- FETCH  output  1  phase strobe.
- EXEC1  output  1  phase strobe.
- EXEC2  output  1  phase strobe.
- IR  output  OPC_W  latched opcode, to the decoder.
- IR_OPERAND  output  DATA_W-OPC_W  latched operand/address field.
- HALTED  output  1  1 while in the HALT state.
- BUSY  output  1  1 in FETCH, EXEC1 or EXEC2.
- CYCLE_CNT  output  CNT_W  count of active phase cycles.
- INSTR_CNT  output  CNT_W  count of completed instructions.

Behaviour:
- States: IDLE, S_FETCH, S_EXEC1, S_EXEC2, HALT.
- Each phase output is a registered one-hot decode of the state; at most one of FETCH/EXEC1/EXEC2 is high in any cycle.
- Reset (asynchronous, RESET_N=0):
  - state=IDLE, step_pending=0.
  - IR=0, IR_OPERAND=0, CYCLE_CNT=0, INSTR_CNT=0.
  - All strobes, HALTED and BUSY = 0.
  - Reset mid-instruction abandons the instruction; nothing is completed or counted.
- IDLE:
  - RUN=1 → S_FETCH.
  - Else STEP=1 → S_FETCH and set step_pending=1.
  - RUN and STEP both 1 → RUN wins; step_pending stays 0.
- S_FETCH:
  - On the exit edge, IR ← MEM_Q[DATA_W-1 -: OPC_W] and IR_OPERAND ← MEM_Q low bits.
  - Always → S_EXEC1. Latency FETCH→EXEC1 is 1 cycle.
- S_EXEC1:
  - IR==STP_OPC → HALT (EXTRA ignored).
  - Else EXTRA=1 → S_EXEC2.
  - Else the instruction completes → next_after.
- S_EXEC2: the instruction completes → next_after.
- next_after:
  - RUN=1 and step_pending=0 → S_FETCH (back-to-back, no bubble).
  - Otherwise → IDLE, with step_pending cleared.
  - RUN dropping mid-instruction: the current instruction finishes, then IDLE.
  - RUN rising during a step: takes effect at the next completion.
- HALT:
  - Absorbing; RUN and STEP are ignored.
  - Exit only via reset.
  - HALTED=1, all strobes 0.
- IR/IR_OPERAND hold their value in every state except the S_FETCH exit edge.
- STEP pulses outside IDLE are ignored, not queued.
- Counters:
  - CYCLE_CNT +1 on every edge with state ∈ {S_FETCH, S_EXEC1, S_EXEC2}.
  - INSTR_CNT +1 on each completion edge, including the S_EXEC1→HALT transition for STP.
  - Both wrap modulo 2^CNT_W with no saturation.
- Instruction lengths: 2 cycles without EXTRA, 3 with EXTRA.
- BUSY = FETCH|EXEC1|EXEC2.

Decomposition:
- Shared package cpu_pkg:
  - State enum.
  - Opcode constants (LDA=0, STA=1, ADD=2, SUB=3, JMP=4, JMI=5, JEQ=6, STP=7, LDI=8, LSR=10, ASR=11).
  - Widths DATA_W and OPC_W.
- Sub-module perf_counter (CNT_W-wide enable counter with async active-low reset), instantiated twice.
- The FSM and IR live in control_sequencer.

Test Plan:
- Reset/idle: RESET_N=0, then 1 with RUN=0 and STEP=0 for 10 cycles → all strobes 0, IR=0, both counters 0, HALTED=0.
- Free-run, no EXTRA: RUN=1, MEM_Q=16'h1005 (STA) every fetch, EXTRA=0 → strobes F,E1,F,E1…; IR=4'h1, IR_OPERAND=12'h005; after 4 instructions INSTR_CNT=4, CYCLE_CNT=8.
- EXTRA path: MEM_Q=16'h2010 (ADD), EXTRA=1 in EXEC1 → F,E1,E2 then F; each instruction adds 3 to CYCLE_CNT and 1 to INSTR_CNT.
- Single step: RUN=0, one-cycle STEP in IDLE, MEM_Q=16'h0020 with EXTRA=1 → exactly F,E1,E2 then IDLE; a second STEP asserted during EXEC1 is ignored; INSTR_CNT=1.
- Halt: RUN=1, MEM_Q=16'h7000 → F, E1, then HALTED=1 permanently; INSTR_CNT increments once; toggling RUN/STEP has no effect; RESET_N pulse → IDLE, HALTED=0.
- Edge cases:
  - RUN dropped during EXEC2 → the instruction finishes, then IDLE.
  - RESET_N asserted during EXEC1 → immediate IDLE, counters 0.
  - CYCLE_CNT preloaded near wrap (CNT_W=4 build) → 15→0 wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, opcode constants and datapath widths.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
    HALT    = 3'd4
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LDA = 4'd0;
  localparam logic [OPC_W-1:0] OPC_STA = 4'd1;
  localparam logic [OPC_W-1:0] OPC_ADD = 4'd2;
  localparam logic [OPC_W-1:0] OPC_SUB = 4'd3;
  localparam logic [OPC_W-1:0] OPC_JMP = 4'd4;
  localparam logic [OPC_W-1:0] OPC_JMI = 4'd5;
  localparam logic [OPC_W-1:0] OPC_JEQ = 4'd6;
  localparam logic [OPC_W-1:0] OPC_STP = 4'd7;
  localparam logic [OPC_W-1:0] OPC_LDI = 4'd8;
  localparam logic [OPC_W-1:0] OPC_LSR = 4'd10;
  localparam logic [OPC_W-1:0] OPC_ASR = 4'd11;

endpackage

// File: rtl/perf_counter.sv
// Free-running enable counter with asynchronous active-low reset; wraps modulo 2^W.
module perf_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: FETCH/EXEC1/EXEC2 phase strobes, instruction register,
// run/single-step control, halt on STP, and cycle/instruction counters.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int                     DATA_W  = cpu_pkg::DATA_W,
  parameter int                     OPC_W   = cpu_pkg::OPC_W,
  parameter int                     CNT_W   = 16,
  parameter logic [OPC_W-1:0]       STP_OPC = cpu_pkg::OPC_STP
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      RUN,
  input  logic                      STEP,
  input  logic                      EXTRA,
  input  logic [DATA_W-1:0]         MEM_Q,
  output logic                      FETCH,
  output logic                      EXEC1,
  output logic                      EXEC2,
  output logic [OPC_W-1:0]          IR,
  output logic [DATA_W-OPC_W-1:0]   IR_OPERAND,
  output logic                      HALTED,
  output logic                      BUSY,
  output logic [CNT_W-1:0]          CYCLE_CNT,
  output logic [CNT_W-1:0]          INSTR_CNT
);

  state_e                    state_q, state_d;
  logic                      step_q, step_d;
  logic [OPC_W-1:0]          ir_q;
  logic [DATA_W-OPC_W-1:0]   opr_q;
  logic                      fetch_q, exec1_q, exec2_q, halted_q;
  logic                      ir_load;
  logic                      instr_done;
  logic                      cycle_en;
  state_e                    after_state;

  // Where a completed instruction goes: keep streaming only in free-run, not in a step.
  always_comb begin
    after_state = (RUN && !step_q) ? S_FETCH : IDLE;
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    ir_load    = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RUN) begin
          state_d = S_FETCH;
        end else if (STEP) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (ir_q == STP_OPC) begin
          state_d    = HALT;
          instr_done = 1'b1;
        end else if (EXTRA) begin
          state_d = S_EXEC2;
        end else begin
          state_d    = after_state;
          instr_done = 1'b1;
          if (after_state == IDLE) step_d = 1'b0;
        end
      end
      S_EXEC2: begin
        state_d    = after_state;
        instr_done = 1'b1;
        if (after_state == IDLE) step_d = 1'b0;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
        step_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      step_q   <= 1'b0;
      fetch_q  <= 1'b0;
      exec1_q  <= 1'b0;
      exec2_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      fetch_q  <= (state_d == S_FETCH);
      exec1_q  <= (state_d == S_EXEC1);
      exec2_q  <= (state_d == S_EXEC2);
      halted_q <= (state_d == HALT);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ir_q  <= '0;
      opr_q <= '0;
    end else if (ir_load) begin
      ir_q  <= MEM_Q[DATA_W-1 -: OPC_W];
      opr_q <= MEM_Q[DATA_W-OPC_W-1:0];
    end
  end

  assign cycle_en = (state_q == S_FETCH) || (state_q == S_EXEC1) || (state_q == S_EXEC2);

  perf_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .en_i   (cycle_en),
    .cnt_o  (CYCLE_CNT)
  );

  perf_counter #(.W(CNT_W)) u_instr_cnt (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .en_i   (instr_done),
    .cnt_o  (INSTR_CNT)
  );

  assign FETCH      = fetch_q;
  assign EXEC1      = exec1_q;
  assign EXEC2      = exec2_q;
  assign HALTED     = halted_q;
  assign BUSY       = fetch_q | exec1_q | exec2_q;
  assign IR         = ir_q;
  assign IR_OPERAND = opr_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer, built with 4-bit counters so wrap is exercised.
module tb_control_sequencer;

  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            RUN, STEP, EXTRA;
  logic [15:0]     MEM_Q;
  logic            FETCH, EXEC1, EXEC2, HALTED, BUSY;
  logic [3:0]      IR;
  logic [11:0]     IR_OPERAND;
  logic [CW-1:0]   CYCLE_CNT, INSTR_CNT;

  control_sequencer #(.DATA_W(16), .OPC_W(4), .CNT_W(CW), .STP_OPC(4'b0111)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .RUN        (RUN),
    .STEP       (STEP),
    .EXTRA      (EXTRA),
    .MEM_Q      (MEM_Q),
    .FETCH      (FETCH),
    .EXEC1      (EXEC1),
    .EXEC2      (EXEC2),
    .IR         (IR),
    .IR_OPERAND (IR_OPERAND),
    .HALTED     (HALTED),
    .BUSY       (BUSY),
    .CYCLE_CNT  (CYCLE_CNT),
    .INSTR_CNT  (INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]    ph;   // {FETCH,EXEC1,EXEC2}
    logic [3:0]    ir;
    logic [11:0]   op;
    logic [CW-1:0] cc;
    logic [CW-1:0] ic;
  } exp_t;

  localparam logic [2:0] PH_F  = 3'b100;
  localparam logic [2:0] PH_E1 = 3'b010;
  localparam logic [2:0] PH_E2 = 3'b001;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  logic [3:0]    m_ir;
  logic [11:0]   m_op;
  logic [CW-1:0] m_cc, m_ic;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every busy cycle must match the next queued expectation.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && BUSY === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_busy", {29'd0, FETCH, EXEC1, EXEC2}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("phase",      {29'd0, FETCH, EXEC1, EXEC2}, {29'd0, e.ph});
        chk("ir",         {28'd0, IR},          {28'd0, e.ir});
        chk("ir_operand", {20'd0, IR_OPERAND},  {20'd0, e.op});
        chk("cycle_cnt",  {28'd0, CYCLE_CNT},   {28'd0, e.cc});
        chk("instr_cnt",  {28'd0, INSTR_CNT},   {28'd0, e.ic});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_quiet(input string name, input logic exp_halted);
    chk({name, "_strobes"}, {29'd0, FETCH, EXEC1, EXEC2}, 32'd0);
    chk({name, "_busy"},    {31'd0, BUSY},   32'd0);
    chk({name, "_halted"},  {31'd0, HALTED}, {31'd0, exp_halted});
    chk({name, "_ir"},      {28'd0, IR},         {28'd0, m_ir});
    chk({name, "_opr"},     {20'd0, IR_OPERAND}, {20'd0, m_op});
    chk({name, "_cyc"},     {28'd0, CYCLE_CNT},  {28'd0, m_cc});
    chk({name, "_ins"},     {28'd0, INSTR_CNT},  {28'd0, m_ic});
    chk({name, "_drained"}, q.size(), 32'd0);
  endtask

  task automatic model_reset();
    m_ir = '0; m_op = '0; m_cc = '0; m_ic = '0;
    q.delete();
  endtask

  // Queue the phase sequence of n back-to-back instructions of word mem.
  task automatic push_instrs(input logic [15:0] mem, input logic extra, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ph = PH_F; e.ir = m_ir; e.op = m_op; e.cc = m_cc; e.ic = m_ic;
      q.push_back(e);
      m_cc = m_cc + 1'b1;
      m_ir = mem[15:12]; m_op = mem[11:0];
      e.ph = PH_E1; e.ir = m_ir; e.op = m_op; e.cc = m_cc; e.ic = m_ic;
      q.push_back(e);
      m_cc = m_cc + 1'b1;
      if (extra) begin
        e.ph = PH_E2; e.cc = m_cc;
        q.push_back(e);
        m_cc = m_cc + 1'b1;
      end
      m_ic = m_ic + 1'b1;
    end
  endtask

  // Free-run n instructions; RUN drops in the final exec phase so the last one finishes.
  task automatic run_instrs(input string name, input logic [15:0] mem, input logic extra, input int n);
    int len;
    len = extra ? 3 : 2;
    MEM_Q = mem; EXTRA = extra;
    push_instrs(mem, extra, n);
    RUN = 1'b1;
    repeat (n * len) tick();
    RUN = 1'b0;
    tick();
    repeat (2) tick();
    check_quiet(name, 1'b0);
  endtask

  initial begin
    exp_t e;
    RESET_N = 1'b0; RUN = 1'b0; STEP = 1'b0; EXTRA = 1'b0; MEM_Q = '0;
    model_reset();
    repeat (3) tick();
    check_quiet("in_reset", 1'b0);
    RESET_N = 1'b1;
    repeat (10) tick();
    check_quiet("idle", 1'b0);

    // STA free-run, 4 instructions of 2 cycles: CYCLE_CNT 8, INSTR_CNT 4
    run_instrs("freerun", 16'h1005, 1'b0, 4);
    // ADD with EXTRA, 2 instructions of 3 cycles: CYCLE_CNT 14, INSTR_CNT 6
    run_instrs("extra", 16'h2010, 1'b1, 2);

    // Single step with EXTRA; second STEP in EXEC1 ignored; CYCLE_CNT wraps 15->0
    MEM_Q = 16'h0020; EXTRA = 1'b1; RUN = 1'b0;
    push_instrs(16'h0020, 1'b1, 1);
    STEP = 1'b1; tick();
    STEP = 1'b0; tick();
    STEP = 1'b1; tick();
    STEP = 1'b0; tick();
    repeat (4) tick();
    check_quiet("step", 1'b0);
    chk("step_wrap_cc", {28'd0, CYCLE_CNT}, 32'd1);

    // RUN dropped during EXEC2: instruction finishes then IDLE
    run_instrs("run_drop_e2", 16'h3abc, 1'b1, 1);

    // Reset asserted during EXEC1 abandons the instruction
    MEM_Q = 16'h5123; EXTRA = 1'b0;
    e.ph = PH_F; e.ir = m_ir; e.op = m_op; e.cc = m_cc; e.ic = m_ic;
    q.push_back(e);
    RUN = 1'b1;
    tick();
    tick();
    chk("pre_reset_exec1", {31'd0, EXEC1}, 32'd1);
    RESET_N = 1'b0; RUN = 1'b0;
    #1;
    model_reset();
    check_quiet("reset_mid", 1'b0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) tick();
    check_quiet("after_reset", 1'b0);

    // STP halts; RUN/STEP then ignored until reset
    MEM_Q = 16'h7000; EXTRA = 1'b1;
    push_instrs(16'h7000, 1'b0, 1);
    RUN = 1'b1;
    repeat (3) tick();
    check_quiet("halt", 1'b1);
    for (int i = 0; i < 6; i++) begin
      RUN = i[0]; STEP = ~i[0];
      tick();
    end
    RUN = 1'b0; STEP = 1'b0;
    tick();
    check_quiet("halt_hold", 1'b1);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    model_reset();
    repeat (2) tick();
    check_quiet("halt_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
